skintone_ellipse_scorer: RTL and testbench

//  Parametrised, stallable successor to the fixed skin-tone ellipse datapath. Takes transformed chroma (Cb',Cr') in

---
 rtl/skintone_pkg.sv | 38 +++
 rtl/skintone_lane.sv | 87 ++++++++
 rtl/skintone_ellipse_scorer.sv | 172 +++++++++++++++++
 tb/tb_skintone_ellipse_scorer.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/skintone_pkg.sv
// Shared constants, config address map and default ellipse constants for the skin-tone scorer.
package skintone_pkg;

    localparam int unsigned SCORE_W  = 8;
    localparam int unsigned N_STAGES = 11;
    localparam int unsigned N_CONST  = 10;

    typedef enum logic [3:0] {
        CFG_CX     = 4'd0,
        CFG_CY     = 4'd1,
        CFG_COST   = 4'd2,
        CFG_SINT   = 4'd3,
        CFG_ECX    = 4'd4,
        CFG_ECY    = 4'd5,
        CFG_A2_INV = 4'd6,
        CFG_B2_INV = 4'd7,
        CFG_RADIUS = 4'd8,
        CFG_FAC    = 4'd9
    } cfg_addr_e;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } cfg_state_e;

    // Default constants as whole multiples of 1.0; scaled to fixed point by the user.
    function automatic int default_int(input int unsigned idx);
        case (idx)
            int'(CFG_COST):   return 1;
            int'(CFG_A2_INV): return 1;
            int'(CFG_B2_INV): return 1;
            int'(CFG_RADIUS): return 1;
            int'(CFG_FAC):    return 100;
            default:          return 0;
        endcase
    endfunction

endpackage

// File: rtl/skintone_lane.sv
// One pixel lane of the ellipse scorer: stages S1..S10, all advancing together on en.
module skintone_lane
    import skintone_pkg::*;
#(
    parameter int unsigned FP_WIDTH = 32,
    parameter int unsigned FP_FRAC  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic signed [FP_WIDTH-1:0] cb,
    input  logic signed [FP_WIDTH-1:0] cr,
    input  logic signed [FP_WIDTH-1:0] cx,
    input  logic signed [FP_WIDTH-1:0] cy,
    input  logic signed [FP_WIDTH-1:0] cost,
    input  logic signed [FP_WIDTH-1:0] sint,
    input  logic signed [FP_WIDTH-1:0] ecx,
    input  logic signed [FP_WIDTH-1:0] ecy,
    input  logic signed [FP_WIDTH-1:0] a2_inv,
    input  logic signed [FP_WIDTH-1:0] b2_inv,
    input  logic signed [FP_WIDTH-1:0] radius,
    input  logic signed [FP_WIDTH-1:0] fac,
    output logic [SCORE_W-1:0]         score
);

    localparam int unsigned W = FP_WIDTH;
    typedef logic signed [W-1:0] fp_t;

    // Full signed product, arithmetic shift back to the fixed-point grid, wrap to W bits.
    function automatic fp_t fmul(input fp_t a, input fp_t b);
        logic signed [2*W-1:0] p;
        p = (2*W)'(a) * (2*W)'(b);
        return W'(p >>> FP_FRAC);
    endfunction

    fp_t u1, v1;
    fp_t cu2, sv2, cv2, su2;
    fp_t x3, y3;
    fp_t dx4, dy4;
    fp_t dx5, dy5;
    fp_t ta6, tb6;
    fp_t d7;
    fp_t r8, s9;
    logic in8, in9;
    logic [SCORE_W-1:0] sat_c;

    always_ff @(posedge clk) begin
        if (en) begin
            u1  <= cb - cx;
            v1  <= cr - cy;
            cu2 <= fmul(cost, u1);
            sv2 <= fmul(sint, v1);
            cv2 <= fmul(cost, v1);
            su2 <= fmul(sint, u1);
            x3  <= cu2 + sv2;
            y3  <= cv2 - su2;
            dx4 <= x3 - ecx;
            dy4 <= y3 - ecy;
            dx5 <= fmul(dx4, dx4);
            dy5 <= fmul(dy4, dy4);
            ta6 <= fmul(a2_inv, dx5);
            tb6 <= fmul(b2_inv, dy5);
            d7  <= ta6 + tb6;
            in8 <= (d7 <= radius);
            r8  <= radius - d7;
            in9 <= in8;
            s9  <= fmul(fac, r8);
        end
    end

    // Integer part of s clamped to 0..255; outside the ellipse scores zero.
    always_comb begin
        sat_c = '0;
        if (in9 && !s9[W-1]) begin
            sat_c = (|s9[W-1:FP_FRAC+SCORE_W]) ? '1 : s9[FP_FRAC +: SCORE_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            score <= '0;
        end else if (en) begin
            score <= sat_c;
        end
    end

endmodule

// File: rtl/skintone_ellipse_scorer.sv
// Stallable multi-lane skin-tone ellipse scorer with shadow/active constants and drain-then-commit.
// Optional frame statistics (stat_count/stat_valid) when SKIN_STATS_EN is defined.
module skintone_ellipse_scorer
    import skintone_pkg::*;
#(
    parameter int unsigned FP_WIDTH = 32,
    parameter int unsigned FP_FRAC  = 16,
    parameter int unsigned LANES    = 1
`ifdef SKIN_STATS_EN
    ,
    parameter int unsigned STAT_THRESH = 128
`endif
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LANES*FP_WIDTH-1:0]   in_cb,
    input  logic [LANES*FP_WIDTH-1:0]   in_cr,
    input  logic                        in_last,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LANES*SCORE_W-1:0]    out_score,
    output logic                        out_last,
    input  logic                        cfg_wr,
    input  logic [3:0]                  cfg_addr,
    input  logic [FP_WIDTH-1:0]         cfg_wdata,
    input  logic                        cfg_commit,
`ifdef SKIN_STATS_EN
    output logic [23:0]                 stat_count,
    output logic                        stat_valid,
`endif
    output logic                        cfg_busy
);

    localparam int unsigned W  = FP_WIDTH;
    localparam int unsigned LW = LANES * FP_WIDTH;

    function automatic logic [W-1:0] def_fp(input int unsigned idx);
        return W'(default_int(idx)) << FP_FRAC;
    endfunction

    logic [W-1:0]          shadow [N_CONST];
    logic [W-1:0]          active [N_CONST];
    cfg_state_e            state, state_next;
    logic                  do_copy;
    logic [N_STAGES-1:0]   vld, lst;
    logic [LW-1:0]         s0_cb, s0_cr;
    logic                  adv, accept, drained;

    assign adv       = !vld[N_STAGES-1] || out_ready;
    assign in_ready  = adv && (state == ST_RUN);
    assign accept    = in_valid && in_ready;
    assign drained   = (vld[N_STAGES-2:0] == '0) && (!vld[N_STAGES-1] || out_ready);
    assign out_valid = vld[N_STAGES-1];
    assign out_last  = lst[N_STAGES-1];

    // Commit waits for an empty pipe so in-flight beats keep their acceptance-time constants.
    always_comb begin
        state_next = state;
        do_copy    = 1'b0;
        case (state)
            ST_RUN:   if (cfg_commit) state_next = ST_DRAIN;
            ST_DRAIN: if (drained) begin
                state_next = ST_RUN;
                do_copy    = 1'b1;
            end
            default:  state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_RUN;
            cfg_busy <= 1'b0;
            vld      <= '0;
            lst      <= '0;
        end else begin
            state    <= state_next;
            cfg_busy <= (state_next == ST_DRAIN);
            if (adv) begin
                vld <= {vld[N_STAGES-2:0], accept};
                lst <= {lst[N_STAGES-2:0], accept && in_last};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            s0_cb <= in_cb;
            s0_cr <= in_cr;
        end
    end

    // A write landing in the copy cycle only reaches the shadow copy.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < N_CONST; i++) begin
                shadow[i] <= def_fp(i);
                active[i] <= def_fp(i);
            end
        end else begin
            if (do_copy) begin
                for (int unsigned i = 0; i < N_CONST; i++) active[i] <= shadow[i];
            end
            if (cfg_wr && (cfg_addr < 4'(N_CONST))) shadow[cfg_addr] <= cfg_wdata;
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        skintone_lane #(
            .FP_WIDTH (FP_WIDTH),
            .FP_FRAC  (FP_FRAC)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .en     (adv),
            .cb     (s0_cb[l*W +: W]),
            .cr     (s0_cr[l*W +: W]),
            .cx     (active[CFG_CX]),
            .cy     (active[CFG_CY]),
            .cost   (active[CFG_COST]),
            .sint   (active[CFG_SINT]),
            .ecx    (active[CFG_ECX]),
            .ecy    (active[CFG_ECY]),
            .a2_inv (active[CFG_A2_INV]),
            .b2_inv (active[CFG_B2_INV]),
            .radius (active[CFG_RADIUS]),
            .fac    (active[CFG_FAC]),
            .score  (out_score[l*SCORE_W +: SCORE_W])
        );
    end

`ifdef SKIN_STATS_EN
    localparam int unsigned STAT_W = 24;

    logic [STAT_W-1:0] stat_acc;
    logic [2:0]        hits;
    logic [STAT_W:0]   sum;
    logic [STAT_W-1:0] sum_sat;

    // Per-frame skin pixel count, saturating, published on the accepted last beat.
    always_comb begin
        hits = '0;
        for (int l = 0; l < LANES; l++) begin
            if (out_score[l*SCORE_W +: SCORE_W] >= SCORE_W'(STAT_THRESH)) hits = hits + 3'd1;
        end
        sum     = {1'b0, stat_acc} + (STAT_W+1)'(hits);
        sum_sat = sum[STAT_W] ? '1 : sum[STAT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_acc   <= '0;
            stat_count <= '0;
            stat_valid <= 1'b0;
        end else begin
            stat_valid <= 1'b0;
            if (out_valid && out_ready) begin
                if (out_last) begin
                    stat_count <= sum_sat;
                    stat_valid <= 1'b1;
                    stat_acc   <= '0;
                end else begin
                    stat_acc <= sum_sat;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_skintone_ellipse_scorer.sv
// Self-checking bench for skintone_ellipse_scorer (2 lanes, 16.16 fixed point).
module tb_skintone_ellipse_scorer;

    localparam int unsigned FPW   = 32;
    localparam int unsigned FPF   = 16;
    localparam int unsigned LANES = 2;
    localparam int unsigned LW    = LANES * FPW;
    localparam int unsigned SW    = LANES * 8;
    localparam longint      ONE   = 65536;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [LW-1:0] in_cb;
    logic [LW-1:0] in_cr;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [SW-1:0] out_score;
    logic          out_last;
    logic          cfg_wr;
    logic [3:0]    cfg_addr;
    logic [FPW-1:0] cfg_wdata;
    logic          cfg_commit;
    logic          cfg_busy;
`ifdef SKIN_STATS_EN
    logic [23:0]   stat_count;
    logic          stat_valid;
`endif

    skintone_ellipse_scorer #(
        .FP_WIDTH (FPW),
        .FP_FRAC  (FPF),
        .LANES    (LANES)
`ifdef SKIN_STATS_EN
        ,
        .STAT_THRESH (100)
`endif
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_cb      (in_cb),
        .in_cr      (in_cr),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_score  (out_score),
        .out_last   (out_last),
        .cfg_wr     (cfg_wr),
        .cfg_addr   (cfg_addr),
        .cfg_wdata  (cfg_wdata),
        .cfg_commit (cfg_commit),
`ifdef SKIN_STATS_EN
        .stat_count (stat_count),
        .stat_valid (stat_valid),
`endif
        .cfg_busy   (cfg_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [SW-1:0] s;
        bit            l;
    } exp_t;

    typedef struct {
        longint cb;
        longint cr;
        int     exp;
    } vec_t;

    int      errors = 0;
    int      checks = 0;
    longint  def_m [10];
    longint  act_m [10];
    longint  sh_m  [10];
    bit      pend;
    exp_t    q [$];
    bit      hold;
    logic [SW-1:0] held_s;
    bit      held_l;
    int      rcv;
    logic [SW-1:0] last_s;
    int      stat_pulses;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint w32(input longint x);
        return longint'(int'(x));
    endfunction

    function automatic longint sx(input logic [31:0] v);
        return longint'($signed(v));
    endfunction

    function automatic longint fm(input longint a, input longint b);
        return w32((a * b) >>> FPF);
    endfunction

    // Reference score from the ellipse equations using the model's active constants.
    function automatic logic [7:0] model(input longint cb, input longint cr);
        longint u, v, x, y, dx, dy, d, s, ip;
        u  = w32(cb - act_m[0]);
        v  = w32(cr - act_m[1]);
        x  = w32(fm(act_m[2], u) + fm(act_m[3], v));
        y  = w32(fm(act_m[2], v) - fm(act_m[3], u));
        dx = w32(x - act_m[4]);
        dy = w32(y - act_m[5]);
        d  = w32(fm(act_m[6], fm(dx, dx)) + fm(act_m[7], fm(dy, dy)));
        if (d > act_m[8]) return 8'd0;
        s  = fm(act_m[9], w32(act_m[8] - d));
        ip = s >>> FPF;
        if (ip < 0) return 8'd0;
        if (ip > 255) return 8'd255;
        return 8'(ip);
    endfunction

    function automatic logic [LW-1:0] pk(input longint a0, input longint a1);
        return {32'(a1), 32'(a0)};
    endfunction

    // One clock cycle: drive, sample mid-cycle, score both handshakes, advance past the edge.
    task automatic step(input bit iv, input logic [LW-1:0] cb, input logic [LW-1:0] cr,
                        input bit lst, input bit ordy, output bit fin);
        exp_t e;
        in_valid  = iv;
        in_cb     = cb;
        in_cr     = cr;
        in_last   = lst;
        out_ready = ordy;
        #3;
        fin = in_valid && in_ready;
        if (rst) begin
            q.delete();
            pend  = 1'b0;
            hold  = 1'b0;
            act_m = def_m;
            sh_m  = def_m;
        end else begin
            if (hold) begin
                checks++;
                if (!out_valid || out_score !== held_s || out_last !== held_l) begin
                    errors++;
                    $display("FAIL stall_hold: got v=%0b s=%h l=%0b expected v=1 s=%h l=%0b",
                             out_valid, out_score, out_last, held_s, held_l);
                end
            end
            if (cfg_busy) chk("drain_in_ready", longint'(in_ready), 0);
            if (out_valid && out_ready) begin
                rcv++;
                last_s = out_score;
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL stale_beat: got score %h expected no beat", out_score);
                end else begin
                    e = q.pop_front();
                    chk("out_score", longint'(out_score), longint'(e.s));
                    chk("out_last", longint'(out_last), longint'(e.l));
                end
            end
            hold   = out_valid && !out_ready;
            held_s = out_score;
            held_l = out_last;
            if (fin) begin
                if (pend) begin
                    act_m = sh_m;
                    pend  = 1'b0;
                end
                e.s = {model(sx(cb[63:32]), sx(cr[63:32])), model(sx(cb[31:0]), sx(cr[31:0]))};
                e.l = lst;
                q.push_back(e);
            end
            if (cfg_commit) pend = 1'b1;
            if (cfg_wr && cfg_addr < 4'd10) sh_m[cfg_addr] = sx(cfg_wdata);
`ifdef SKIN_STATS_EN
            if (stat_valid) stat_pulses++;
`endif
        end
        @(posedge clk);
        #1;
        cfg_wr     = 1'b0;
        cfg_commit = 1'b0;
    endtask

    task automatic idle(input int n);
        bit f;
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b1, f);
    endtask

    task automatic send1(input logic [LW-1:0] cb, input logic [LW-1:0] cr, input bit lst);
        bit f;
        int n;
        f = 1'b0;
        n = 0;
        while (!f && n < 60) begin
            step(1'b1, cb, cr, lst, 1'b1, f);
            n++;
        end
        if (!f) chk("accept_timeout", n, 0);
    endtask

    task automatic drain();
        bit f;
        int n;
        n = 0;
        while ((q.size() != 0 || out_valid) && n < 100) begin
            step(1'b0, '0, '0, 1'b0, 1'b1, f);
            n++;
        end
        if (n >= 100) chk("drain_timeout", longint'(q.size()), 0);
    endtask

    task automatic cfg_write(input int a, input longint v);
        bit f;
        cfg_wr    = 1'b1;
        cfg_addr  = 4'(a);
        cfg_wdata = 32'(v);
        step(1'b0, '0, '0, 1'b0, 1'b1, f);
    endtask

    task automatic cfg_commit_req();
        bit f;
        cfg_commit = 1'b1;
        step(1'b0, '0, '0, 1'b0, 1'b1, f);
    endtask

    task automatic do_reset();
        bit f;
        rst = 1'b1;
        step(1'b0, '0, '0, 1'b0, 1'b1, f);
        rst = 1'b0;
    endtask

    function automatic longint rnd_fp(input int span);
        return longint'($urandom_range(0, 2 * span)) - longint'(span);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tv [10];
        bit   f;
        int   lat, sent, rcv0, i, cnt;
        logic [LW-1:0] cbv, crv;

        def_m = '{0, 0, ONE, 0, 0, 0, ONE, ONE, ONE, 100 * ONE};
        tv[0] = '{0,            0,             100};
        tv[1] = '{2 * ONE,      0,             0};
        tv[2] = '{ONE / 2,      0,             75};
        tv[3] = '{0,            ONE / 2,       75};
        tv[4] = '{ONE,          0,             0};
        tv[5] = '{ONE / 2,      ONE / 2,       50};
        tv[6] = '{-ONE / 2,     0,             75};
        tv[7] = '{ONE / 4,      0,             93};
        tv[8] = '{0,            -3 * ONE / 2,  0};
        tv[9] = '{ONE / 2,      -ONE / 4,      68};

        rst = 1'b1; in_valid = 1'b0; in_cb = '0; in_cr = '0; in_last = 1'b0;
        out_ready = 1'b1; cfg_wr = 1'b0; cfg_addr = '0; cfg_wdata = '0; cfg_commit = 1'b0;
        rcv = 0; stat_pulses = 0; hold = 1'b0; pend = 1'b0;
        act_m = def_m; sh_m = def_m;

        do_reset();
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_out_score", longint'(out_score), 0);
        chk("rst_out_last", longint'(out_last), 0);
        chk("rst_cfg_busy", longint'(cfg_busy), 0);
        chk("rst_in_ready", longint'(in_ready), 1);

        // Latency from accept to out_valid
        send1(pk(0, 0), pk(0, 0), 1'b0);
        lat = 1;
        while (!out_valid && lat < 40) begin
            step(1'b0, '0, '0, 1'b0, 1'b1, f);
            lat++;
        end
        chk("latency", lat, 11);
        drain();
        chk("center_score", longint'(last_s[7:0]), 100);

        for (int k = 0; k < 10; k++) begin
            send1(pk(tv[k].cb, tv[k].cr), pk(tv[k].cr, tv[k].cb), 1'b0);
            drain();
            chk($sformatf("vec%0d_lane0", k), longint'(last_s[7:0]), tv[k].exp);
            chk($sformatf("vec%0d_lane1", k), longint'(last_s[15:8]), tv[k].exp);
        end

        // Saturation with a large gain
        cfg_write(9, 1000 * ONE);
        cfg_commit_req();
        send1(pk(0, 2 * ONE), pk(0, 0), 1'b0);
        drain();
        chk("sat_lane0", longint'(last_s[7:0]), 255);
        chk("sat_lane1", longint'(last_s[15:8]), 0);
        cfg_write(9, 100 * ONE);
        cfg_write(12, 7 * ONE);
        cfg_commit_req();

        // 20-beat stream against a fixed stall pattern
        sent = 0; rcv0 = rcv; i = 0;
        while ((sent < 20 || rcv - rcv0 < 20) && i < 400) begin
            cbv = pk(rnd_fp(3 * ONE / 2), rnd_fp(3 * ONE / 2));
            crv = pk(rnd_fp(3 * ONE / 2), rnd_fp(3 * ONE / 2));
            if (sent < 20) begin
                step(1'b1, cbv, crv, sent == 19, !((i >= 5 && i <= 9) || (i % 3 == 2)), f);
                if (f) sent++;
            end else begin
                step(1'b0, '0, '0, 1'b0, !((i >= 5 && i <= 9) || (i % 3 == 2)), f);
            end
            i++;
        end
        chk("stream20_count", rcv - rcv0, 20);
        chk("stream20_queue", longint'(q.size()), 0);

        // Rotated, offset ellipse with random traffic and stalls
        cfg_write(0, rnd_fp(ONE / 8));
        cfg_write(1, rnd_fp(ONE / 8));
        cfg_write(2, 60547);
        cfg_write(3, 25080);
        cfg_write(4, rnd_fp(ONE / 4));
        cfg_write(5, rnd_fp(ONE / 4));
        cfg_write(6, 2 * ONE);
        cfg_write(7, 3 * ONE / 4);
        cfg_write(8, ONE);
        cfg_write(9, 300 * ONE);
        cfg_commit_req();
        sent = 0; rcv0 = rcv; i = 0;
        while ((sent < 30 || rcv - rcv0 < 30) && i < 600) begin
            cbv = pk(rnd_fp(ONE), rnd_fp(ONE));
            crv = pk(rnd_fp(ONE), rnd_fp(ONE));
            step(sent < 30 && ($urandom_range(0, 4) != 0), cbv, crv, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) != 0, f);
            if (f) sent++;
            i++;
        end
        chk("stream30_count", rcv - rcv0, 30);

        // Commit with six beats in flight
        do_reset();
        for (int k = 0; k < 6; k++) send1(pk(0, 0), pk(0, 0), 1'b0);
        cfg_write(9, 50 * ONE);
        cfg_commit_req();
        chk("commit_busy", longint'(cfg_busy), 1);
        chk("commit_in_ready", longint'(in_ready), 0);
        send1(pk(0, 0), pk(0, 0), 1'b0);
        drain();
        chk("commit_new_fac", longint'(last_s[7:0]), 50);
        chk("commit_busy_clear", longint'(cfg_busy), 0);

        // Reset mid-stream
        for (int k = 0; k < 5; k++) step(1'b1, pk(0, 0), pk(0, 0), 1'b0, 1'b1, f);
        do_reset();
        chk("midrst_out_valid", longint'(out_valid), 0);
        cnt = 0;
        for (int k = 0; k < 15; k++) begin
            if (out_valid) cnt++;
            step(1'b0, '0, '0, 1'b0, 1'b1, f);
        end
        chk("midrst_no_stale", cnt, 0);
        send1(pk(0, 0), pk(0, 0), 1'b0);
        drain();
        chk("midrst_default_fac", longint'(last_s[7:0]), 100);

`ifdef SKIN_STATS_EN
        do_reset();
        stat_pulses = 0;
        send1(pk(0, 2 * ONE), pk(0, 0), 1'b0);
        send1(pk(0, 0), pk(0, 0), 1'b0);
        send1(pk(2 * ONE, 2 * ONE), pk(0, 0), 1'b0);
        send1(pk(0, 2 * ONE), pk(0, 0), 1'b1);
        drain();
        idle(3);
        chk("stat_count", longint'(stat_count), 4);
        chk("stat_pulses", stat_pulses, 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
